// File: rtl/alu_writeback_pkg.sv
// Shared BPF writeback definitions: writeback/jump command codes and the FSM
// state encoding used by the controller, the writeback block and the benches.
package alu_writeback_pkg;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_A    = 2'b01;
    localparam logic [1:0] WB_X    = 2'b10;

    localparam logic [2:0] JMP_NEXT = 3'b000;
    localparam logic [2:0] JMP_JA   = 3'b001;
    localparam logic [2:0] JMP_JEQ  = 3'b010;
    localparam logic [2:0] JMP_JGT  = 3'b011;
    localparam logic [2:0] JMP_JGE  = 3'b100;
    localparam logic [2:0] JMP_JSET = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_COMMIT = 2'b10
    } wb_state_e;

    // Codes 11x are reserved and behave as a plain fall-through.
    function automatic logic is_jump(input logic [2:0] cond);
        return (cond >= JMP_JA) && (cond <= JMP_JSET);
    endfunction

    function automatic logic branch_taken(input logic [2:0] cond, input logic eq,
                                          input logic gt, input logic ge, input logic set);
        return (cond == JMP_JA) || ((cond == JMP_JEQ) && eq) || ((cond == JMP_JGT) && gt) ||
               ((cond == JMP_JGE) && ge) || ((cond == JMP_JSET) && set);
    endfunction

endpackage

// File: rtl/alu_writeback_branch_resolve.sv
// Combinational next-PC resolution from the captured jump code, offsets and
// ALU compare flags. Sum is taken modulo 2**PC_WIDTH.
module alu_writeback_branch_resolve
    import alu_writeback_pkg::*;
#(
    parameter int PC_WIDTH = 10
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [2:0]          cond_i,
    input  logic [7:0]          jt_i,
    input  logic [7:0]          jf_i,
    input  logic                eq_i,
    input  logic                gt_i,
    input  logic                ge_i,
    input  logic                set_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [7:0]          offset;
    logic [PC_WIDTH-1:0] offset_ext;

    always_comb begin
        offset = 8'd0;
        if (is_jump(cond_i)) begin
            offset = branch_taken(cond_i, eq_i, gt_i, ge_i, set_i) ? jt_i : jf_i;
        end
        offset_ext = PC_WIDTH'(offset);
        pc_next_o  = pc_i + PC_WIDTH'(1) + offset_ext;
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage of a packet-filter core: accepts a command, waits for the
// ALU result, writes A or X and resolves the next PC. Owns A, X and PC.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int PC_WIDTH   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            jmp_cond,
    input  logic [7:0]            jt,
    input  logic [7:0]            jf,
    input  logic                  pc_clr,
    input  logic [DATA_WIDTH-1:0] ALU_out,
    input  logic                  set,
    input  logic                  eq,
    input  logic                  gt,
    input  logic                  ge,
    input  logic                  ALU_vld,
    output logic                  ALU_ack,
    output logic [DATA_WIDTH-1:0] A_reg,
    output logic [DATA_WIDTH-1:0] X_reg,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  done
);

    // Handshakes: a command transfers on an edge with cmd_vld && cmd_rdy; an ALU
    // result transfers on the first edge in WAIT with ALU_vld, and ALU_ack is the
    // following one-cycle COMMIT acknowledgement, so it never precedes capture.

    wb_state_e             state_q, state_d;
    logic [1:0]            wb_sel_q;
    logic [2:0]            jmp_q;
    logic [7:0]            jt_q, jf_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  eq_q, gt_q, ge_q, set_q;
    logic [DATA_WIDTH-1:0] a_q, a_d, x_q, x_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_branch;
    logic                  accept, capture, commit;

    assign accept  = (state_q == ST_IDLE) && cmd_vld;
    assign capture = (state_q == ST_WAIT) && ALU_vld;
    assign commit  = (state_q == ST_COMMIT);

    alu_writeback_branch_resolve #(.PC_WIDTH(PC_WIDTH)) u_branch (
        .pc_i      (pc_q),
        .cond_i    (jmp_q),
        .jt_i      (jt_q),
        .jf_i      (jf_q),
        .eq_i      (eq_q),
        .gt_i      (gt_q),
        .ge_i      (ge_q),
        .set_i     (set_q),
        .pc_next_o (pc_branch)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE:   if (cmd_vld) state_d = ST_WAIT;
            ST_WAIT:   if (ALU_vld) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (commit) begin
            if (wb_sel_q == WB_A) a_d = res_q;
            if (wb_sel_q == WB_X) x_d = res_q;
            pc_d = pc_branch;
        end
        // A new packet restarts the program even if a commit lands on the same edge.
        if (pc_clr) pc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wb_sel_q <= WB_NONE;
            jmp_q    <= JMP_NEXT;
            jt_q     <= 8'd0;
            jf_q     <= 8'd0;
            res_q    <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            ge_q     <= 1'b0;
            set_q    <= 1'b0;
            a_q      <= '0;
            x_q      <= '0;
            pc_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            pc_q    <= pc_d;
            if (accept) begin
                wb_sel_q <= wb_sel;
                jmp_q    <= jmp_cond;
                jt_q     <= jt;
                jf_q     <= jf;
            end
            if (capture) begin
                res_q <= ALU_out;
                eq_q  <= eq;
                gt_q  <= gt;
                ge_q  <= ge;
                set_q <= set;
            end
        end
    end

    assign cmd_rdy = (state_q == ST_IDLE);
    assign ALU_ack = commit;
    assign done    = commit;
    assign A_reg   = a_q;
    assign X_reg   = x_q;
    assign pc      = pc_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed plus randomized bench for alu_writeback against a behavioural model
// of the A/X/PC architectural state.
module tb_alu_writeback;

    localparam int PW = 10;
    localparam int DW = 32;

    logic          clk, rst_n;
    logic          cmd_vld, cmd_rdy;
    logic [1:0]    wb_sel;
    logic [2:0]    jmp_cond;
    logic [7:0]    jt, jf;
    logic          pc_clr;
    logic [DW-1:0] ALU_out;
    logic          set, eq, gt, ge;
    logic          ALU_vld, ALU_ack;
    logic [DW-1:0] A_reg, X_reg;
    logic [PW-1:0] pc;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] m_a, m_x;
    int            m_pc;

    alu_writeback #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .wb_sel(wb_sel), .jmp_cond(jmp_cond), .jt(jt), .jf(jf), .pc_clr(pc_clr),
        .ALU_out(ALU_out), .set(set), .eq(eq), .gt(gt), .ge(ge),
        .ALU_vld(ALU_vld), .ALU_ack(ALU_ack), .A_reg(A_reg), .X_reg(X_reg),
        .pc(pc), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC from the architectural rules, in plain integer arithmetic.
    function automatic int ref_pc(input int cur, input int cond, input int t, input int f,
                                  input bit e, input bit g, input bit ge_f, input bit s);
        bit taken;
        if (cond == 0 || cond > 5) return (cur + 1) % (1 << PW);
        taken = (cond == 1) || (cond == 2 && e) || (cond == 3 && g) ||
                (cond == 4 && ge_f) || (cond == 5 && s);
        return (cur + 1 + (taken ? t : f)) % (1 << PW);
    endfunction

    task automatic check_arch(input string tag);
        check({tag, "_A"}, A_reg, m_a);
        check({tag, "_X"}, X_reg, m_x);
        check({tag, "_pc"}, DW'(pc), DW'(m_pc));
    endtask

    // One full command: accept, optional stall, result, commit.
    task automatic txn(input int wb, input int cond, input int t, input int f,
                       input logic [DW-1:0] data, input bit e, input bit g, input bit ge_f,
                       input bit s, input int delay, input bit clr, input bit hold);
        check("rdy_idle", DW'(cmd_rdy), 1);
        wb_sel = 2'(wb); jmp_cond = 3'(cond); jt = 8'(t); jf = 8'(f);
        cmd_vld = 1'b1;
        tick();
        cmd_vld  = 1'b0;
        wb_sel   = 2'($urandom);
        jmp_cond = 3'($urandom);
        jt       = 8'($urandom);
        jf       = 8'($urandom);
        for (int i = 0; i < delay; i++) begin
            check("wait_rdy", DW'(cmd_rdy), 0);
            check("wait_ack", DW'(ALU_ack), 0);
            check("wait_done", DW'(done), 0);
            tick();
        end
        ALU_out = data; eq = e; gt = g; ge = ge_f; set = s;
        ALU_vld = 1'b1;
        tick();
        check("commit_ack", DW'(ALU_ack), 1);
        check("commit_done", DW'(done), 1);
        check("commit_rdy", DW'(cmd_rdy), 0);
        check_arch("commit_hold");
        if (hold) begin
            ALU_out = ~data;
            eq = ~e; gt = ~g; ge = ~ge_f; set = ~s;
        end else begin
            ALU_vld = 1'b0;
        end
        pc_clr = clr;
        tick();
        ALU_vld = 1'b0;
        pc_clr  = 1'b0;
        if (wb == 1) m_a = data;
        if (wb == 2) m_x = data;
        m_pc = clr ? 0 : ref_pc(m_pc, cond, t, f, e, g, ge_f, s);
        check("post_ack", DW'(ALU_ack), 0);
        check("post_done", DW'(done), 0);
        check("post_rdy", DW'(cmd_rdy), 1);
        check_arch("post");
    endtask

    // Steer the PC to a target using pc_clr then JA / fall-through commands.
    task automatic set_pc(input int target);
        int step;
        pc_clr = 1'b1;
        tick();
        pc_clr = 1'b0;
        m_pc = 0;
        check("set_pc_clr", DW'(pc), 0);
        while (m_pc != target) begin
            step = target - m_pc;
            if (step > 256) step = 256;
            if (step == 1) txn(0, 0, 0, 0, $urandom, 0, 0, 0, 0, 0, 0, 0);
            else txn(0, 1, step - 1, $urandom_range(255), $urandom, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; wb_sel = 2'd0; jmp_cond = 3'd0; jt = 8'd0; jf = 8'd0;
        pc_clr = 1'b0; ALU_out = '0; set = 1'b0; eq = 1'b0; gt = 1'b0; ge = 1'b0;
        ALU_vld = 1'b0;
        m_a = '0; m_x = '0; m_pc = 0;
        repeat (2) tick();
        check("rst_rdy", DW'(cmd_rdy), 1);
        check("rst_ack", DW'(ALU_ack), 0);
        check("rst_done", DW'(done), 0);
        check_arch("rst");
        rst_n = 1'b1;
        tick();

        // Writeback to A with the result one cycle after accept.
        txn(1, 0, 0, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0);
        txn(2, 0, 0, 0, 32'hCAFE_0042, 0, 0, 0, 0, 1, 0, 0);

        // Reset asserted mid-WAIT takes effect without waiting for a clock.
        wb_sel = 2'd1; jmp_cond = 3'd1; jt = 8'd9; cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        tick();
        check("midwait_rdy", DW'(cmd_rdy), 0);
        rst_n = 1'b0;
        #1;
        m_a = '0; m_x = '0; m_pc = 0;
        check("arst_rdy", DW'(cmd_rdy), 1);
        check("arst_ack", DW'(ALU_ack), 0);
        check_arch("arst");
        ALU_vld = 1'b1; ALU_out = 32'hDEAD_BEEF;
        tick();
        ALU_vld = 1'b0;
        rst_n = 1'b1;
        tick();
        check("arst_drop_ack", DW'(ALU_ack), 0);
        check_arch("arst_drop");

        // JGT taken and not taken from pc=5.
        set_pc(5);
        txn(0, 3, 3, 7, $urandom, 0, 1, 0, 0, 0, 0, 0);
        check("jgt_taken", DW'(pc), 9);
        set_pc(5);
        txn(0, 3, 3, 7, $urandom, 0, 0, 0, 0, 0, 0, 0);
        check("jgt_not", DW'(pc), 13);

        // PC wrap-around.
        set_pc(1020);
        txn(0, 1, 8, 0, $urandom, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_ja", DW'(pc), 5);
        set_pc(1023);
        txn(0, 5, 200, 0, $urandom, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_jset", DW'(pc), 0);

        // ALU_vld while idle is not acknowledged and changes nothing.
        ALU_vld = 1'b1; ALU_out = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_vld_ack", DW'(ALU_ack), 0);
            check("idle_vld_rdy", DW'(cmd_rdy), 1);
        end
        ALU_vld = 1'b0;
        check_arch("idle_vld");

        // Long ALU stall followed by a normal commit.
        txn(1, 2, 4, 6, 32'h0BAD_F00D, 1, 0, 0, 0, 20, 0, 0);

        // pc_clr on the commit edge: PC cleared, X still written.
        txn(2, 1, 30, 0, 32'd77, 0, 0, 0, 0, 0, 1, 0);
        check("coll_pc", DW'(pc), 0);
        check("coll_x", X_reg, 32'd77);

        // Randomized commands, including reserved codes and ALU_vld held into COMMIT.
        for (int n = 0; n < 40; n++) begin
            txn($urandom_range(3), $urandom_range(7), $urandom_range(255), $urandom_range(255),
                $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(3), ($urandom_range(7) == 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
